// File: rtl/player_state_engine.sv
// Fighting-game player state engine: tick-paced movement, jump, crouch, attack, stun and KO.
// Optional macro BLOCK_CHIP_DAMAGE_EN makes blocked hits deal hitDamage >> 2.
module player_state_engine #(
   parameter logic [9:0]        X_MIN        = 10'd16,
   parameter logic [9:0]        X_MAX        = 10'd600,
   parameter logic [9:0]        X_START      = 10'd100,
   parameter int                WALK_STEP    = 4,
   parameter logic signed [7:0] JUMP_VEL     = 8'sd12,
   parameter int                GRAVITY      = 1,
   parameter int                CROUCH_TICKS = 8,
   parameter int                ATK1_TICKS   = 6,
   parameter int                ATK2_TICKS   = 10,
   parameter int                ATK3_TICKS   = 16,
   parameter int                STUN_TICKS   = 12,
   parameter logic [7:0]        HEALTH_INIT  = 8'd200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       gameTicks,
   input  logic       movingLeft,
   input  logic       movingRight,
   input  logic       isJumping,
   input  logic       isCrouching,
   input  logic       isBlocking,
   input  logic [1:0] comboMove,
   input  logic       hitReceived,
   input  logic [7:0] hitDamage,
   output logic [9:0] xPos,
   output logic [7:0] yPos,
   output logic [7:0] health,
   output logic       isCrouched,
   output logic       isInAir,
   output logic       isStunned,
   output logic       isPerformingAttackAnimation,
   output logic       isKO,
   output logic [1:0] attackType,
   output logic       attackStrike
);

   typedef enum logic [2:0] {S_IDLE, S_CROUCH, S_AIR, S_ATTACK, S_STUN, S_KO} state_e;

   localparam logic [10:0]       STEP11  = 11'(WALK_STEP);
   localparam logic signed [7:0] GRAV_S  = 8'(GRAVITY);
   localparam logic [7:0]        CROUCH_T = 8'(CROUCH_TICKS);
   localparam logic [7:0]        STUN_T  = 8'(STUN_TICKS);

   state_e            state_q, state_d;
   logic [9:0]        x_q, x_d;
   logic [7:0]        y_q, y_d;
   logic signed [7:0] vy_q, vy_d;
   logic [7:0]        hp_q, hp_d;
   logic [7:0]        timer_q, timer_d;
   logic [1:0]        atk_q, atk_d;
   logic              strike_q, strike_d;
   logic              pend_q, pend_d;
   logic              game_ticks_q, game_ticks_d;

   logic              tick;
   logic [10:0]       x_ext, x_plus;
   logic [9:0]        x_step;
   logic signed [9:0] y_sum;
   logic [7:0]        timer_dec;
   logic              blocked;
   logic [7:0]        dmg, hp_sub;
   logic [7:0]        atk_ticks;

   assign tick = gameTicks & ~game_ticks_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q          <= X_START;
         y_q          <= 8'd0;
         vy_q         <= 8'sd0;
         hp_q         <= HEALTH_INIT;
         timer_q      <= 8'd0;
         atk_q        <= 2'd0;
         strike_q     <= 1'b0;
         pend_q       <= 1'b0;
         game_ticks_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         vy_q         <= vy_d;
         hp_q         <= hp_d;
         timer_q      <= timer_d;
         atk_q        <= atk_d;
         strike_q     <= strike_d;
         pend_q       <= pend_d;
         game_ticks_q <= game_ticks_d;
      end
   end

   // Datapath helpers: clamped walk at 11 bits, signed height sum, saturating damage.
   always_comb begin
      x_ext  = {1'b0, x_q};
      x_plus = x_ext + STEP11;
      x_step = x_q;
      if (movingLeft && !movingRight)
         x_step = (x_ext < 11'(X_MIN) + STEP11) ? X_MIN : 10'(x_ext - STEP11);
      else if (movingRight && !movingLeft)
         x_step = (x_plus > 11'(X_MAX)) ? X_MAX : x_plus[9:0];
      y_sum     = $signed({2'b00, y_q}) + $signed({{2{vy_q[7]}}, vy_q});
      timer_dec = (timer_q == 8'd0) ? 8'd0 : timer_q - 8'd1;
      blocked   = isBlocking && (state_q == S_IDLE || state_q == S_CROUCH);
`ifdef BLOCK_CHIP_DAMAGE_EN
      dmg = blocked ? (hitDamage >> 2) : hitDamage;
`else
      dmg = blocked ? 8'd0 : hitDamage;
`endif
      hp_sub = (dmg >= hp_q) ? 8'd0 : hp_q - dmg;
      case (comboMove)
         2'd1:    atk_ticks = 8'(ATK1_TICKS);
         2'd2:    atk_ticks = 8'(ATK2_TICKS);
         default: atk_ticks = 8'(ATK3_TICKS);
      endcase
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      vy_d         = vy_q;
      hp_d         = hp_q;
      timer_d      = timer_q;
      atk_d        = atk_q;
      strike_d     = 1'b0;
      pend_d       = pend_q;
      game_ticks_d = gameTicks;
      if (state_q == S_KO) begin
         state_d = S_KO;
      end else if (hitReceived) begin
         // A hit pre-empts any coincident tick.
         hp_d = hp_sub;
         if (hp_sub == 8'd0 || !blocked) begin
            state_d = (hp_sub == 8'd0) ? S_KO : S_STUN;
            timer_d = (hp_sub == 8'd0) ? 8'd0 : STUN_T;
            y_d     = 8'd0;
            vy_d    = 8'sd0;
            atk_d   = 2'd0;
            pend_d  = 1'b0;
         end
      end else if (tick) begin
         if (state_q == S_IDLE || state_q == S_AIR) x_d = x_step;
         case (state_q)
            S_IDLE, S_CROUCH: begin
               if (comboMove != 2'd0) begin
                  state_d = S_ATTACK;
                  atk_d   = comboMove;
                  timer_d = atk_ticks;
                  pend_d  = 1'b1;
               end else if (state_q == S_CROUCH) begin
                  timer_d = timer_dec;
                  if (timer_dec == 8'd0) state_d = S_IDLE;
               end else if (isJumping) begin
                  state_d = S_AIR;
                  vy_d    = JUMP_VEL;
               end else if (isCrouching) begin
                  state_d = S_CROUCH;
                  timer_d = CROUCH_T;
               end
            end
            S_AIR: begin
               if (y_sum <= 10'sd0) begin
                  y_d     = 8'd0;
                  vy_d    = 8'sd0;
                  state_d = S_IDLE;
               end else begin
                  y_d  = y_sum[7:0];
                  vy_d = vy_q - GRAV_S;
               end
            end
            S_ATTACK: begin
               strike_d = pend_q;
               pend_d   = 1'b0;
               timer_d  = timer_dec;
               if (timer_dec == 8'd0) begin
                  state_d = S_IDLE;
                  atk_d   = 2'd0;
               end
            end
            S_STUN: begin
               timer_d = timer_dec;
               if (timer_dec == 8'd0) state_d = S_IDLE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      isCrouched                  = (state_q == S_CROUCH);
      isInAir                     = (state_q == S_AIR);
      isPerformingAttackAnimation = (state_q == S_ATTACK);
      isStunned                   = (state_q == S_STUN) || (state_q == S_KO);
      isKO                        = (state_q == S_KO);
      xPos                        = x_q;
      yPos                        = y_q;
      health                      = hp_q;
      attackType                  = atk_q;
      attackStrike                = strike_q;
   end

endmodule
